seq_det_prog: RTL and testbench
===============================

# seq_det_prog

Programmable serial pattern detector, successor to the fixed 4-bit sequence detector. It samples one serial bit per enabled clock and compares the most recent bits against a runtime-loadable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping matching is selectable. Each hit produces a registered one-cycle `z` pulse and increments a saturating hit counter. It sits on a serial data path as a framing/sync-word detector.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 16: width of the hit counter.
- `RST_PATTERN`, 8'b0000_0110: pattern loaded at reset (LSB-aligned).
- `RST_LEN`, 4: pattern length loaded at reset.
- `RST_OVERLAP`, 1: overlap mode loaded at reset.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `en` in 1: `x` is valid this cycle.
- `x` in 1: serial data bit.
- `cfg_load` in 1: latch the `cfg_*` inputs this cycle.
- `cfg_pattern` in MAX_LEN: pattern, LSB-aligned. Bit [len-1] is received first, bit [0] last.
- `cfg_len` in $clog2(MAX_LEN+1): pattern length.
- `cfg_overlap` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr` in 1: synchronous clear of `match_count`.
- `z` out 1: registered match pulse.
- `match_count` out CNT_W: saturating hit count.
- `cfg_err` out 1: the active `len` is 0 or greater than MAX_LEN.

## Operation
- Registers:
  - `pat`, `len`, `ovl`: active configuration.
  - `hist[MAX_LEN-1:0]`: shift register, newest bit in `hist[0]`.
  - `fill`: count of valid history bits, 0..MAX_LEN.
  - `z`, `match_count`.
- On a cycle with `en`=1 (and no `cfg_load`):
  - `hist_n = {hist[MAX_LEN-2:0], x}`
  - `fill_n = min(fill+1, MAX_LEN)`
  - `hit = !cfg_err && fill_n ≥ len && (hist_n & mask(len)) == (pat & mask(len))`, where `mask(len)` has the low `len` bits set.
- On a hit:
  - `z` <= 1 for exactly one cycle.
  - `match_count` increments, saturating at all-ones.
  - If `ovl`=0, `fill` <= 0, so the completing bit cannot start the next match.
  - If `ovl`=1, `fill` <= `fill_n`.
- No hit, or `en`=0: `z` <= 0. When `en`=0, `hist` and `fill` hold.
- Derived states:
  - DISABLED: `cfg_err`=1. No hits; the history still shifts.
  - FILLING: `fill` < `len`.
  - ARMED: `fill` ≥ `len`.
  - Transitions: FILLING→ARMED as `fill` grows; ARMED→FILLING on a non-overlap hit or on `cfg_load`.
- `cfg_load`:
  - Latches `pat`, `len`, `ovl`; clears `hist` and `fill`; drives `z` <= 0.
  - Has priority over `en`: a bit presented in the same cycle is dropped.
  - `match_count` is unaffected.
- `cnt_clr`: `match_count` <= 0, and it wins over a simultaneous hit (result is 0). `z` still pulses for that hit.
- Reset (`reset_n`=0 at a rising edge):
  - `pat`=RST_PATTERN, `len`=RST_LEN, `ovl`=RST_OVERLAP.
  - `hist`=0, `fill`=0, `z`=0, `match_count`=0, `cfg_err`=(RST_LEN==0 || RST_LEN>MAX_LEN).
  - A reset mid-stream discards any partial match.

## Timing
- `z` is registered. It is high during the cycle after the rising edge that samples the completing bit.
- `match_count` updates on that same edge.
- Latency from completing bit to `z` is 1 clk.
- With `en` held high, back-to-back hits give consecutive `z` pulses (for example, pattern `11` with overlap on a run of 1s).
- A new configuration takes effect for bits sampled from the edge after `cfg_load`.
- `cfg_err` updates on the same edge as `len`.
- No combinational path from inputs to outputs.

## Structure
- Package `seq_det_pkg`:
  - reset-default constants;
  - `len_t` typedef;
  - function `len_mask(len)` returning MAX_LEN bits.
- Sub-module `sat_counter` (parameter W; ports `inc`, `clr`; clear wins; saturating) implements `match_count`.
- Everything else lives in the top-level module.

## Test plan
- Reset defaults (pattern 0110, overlap on). Stream 0,1,1,0,1,1,0 with `en`=1 → `z` pulses after bits 4 and 7; `match_count`=2.
- `cfg_load` pattern 101, len 3, overlap 1. Stream 1,0,1,0,1 → `z` after bits 3 and 5; count 2. Repeat with overlap 0 → `z` after bit 3 only; count 1.
- `en` gaps: pattern 0110 fed as 0,(en=0),1,(en=0)×3,1,0 → exactly one `z`, one cycle after the final 0.
- Boundaries:
  - len 8, pattern 0xA5 → no `z` before 8 bits, then a hit.
  - len 0 → `cfg_err`=1, never a `z`.
  - len 9 with MAX_LEN 8 → `cfg_err`=1.
- Counter: CNT_W=2 with 5 hits → `match_count` saturates at 3. `cnt_clr` coincident with a hit → count 0, `z` still 1.
- `reset_n` low after bits 0,1,1 of 0110, then 0 → no `z`. `cfg_load` coincident with a completing bit → bit dropped, no `z`, history cleared.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the programmable sequence detector.
package seq_det_pkg;

  localparam int                 SEQ_MAX_LEN     = 8;
  localparam int                 SEQ_LEN_W       = $clog2(SEQ_MAX_LEN + 1);
  localparam logic [SEQ_MAX_LEN-1:0] SEQ_RST_PATTERN = 8'b0000_0110;
  localparam int                 SEQ_RST_LEN     = 4;
  localparam logic               SEQ_RST_OVERLAP = 1'b1;

  typedef logic [SEQ_LEN_W-1:0] len_t;

  // Mask with the low 'len' bits set; lengths above SEQ_MAX_LEN give all ones.
  function automatic logic [SEQ_MAX_LEN-1:0] len_mask(input len_t len);
    logic [SEQ_MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < SEQ_MAX_LEN; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, then increment unless already all ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: compares the newest 'len' history bits
// against a loadable pattern and pulses z (registered) on every hit.
//
// state    | meaning
// DISABLED | cfg_err set, history shifts but no hits are reported
// FILLING  | fewer than len valid history bits collected
// ARMED    | enough valid bits; every enabled bit may complete a match
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                   MAX_LEN     = SEQ_MAX_LEN,
  parameter int                   CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = SEQ_RST_PATTERN,
  parameter int                   RST_LEN     = SEQ_RST_LEN,
  parameter logic                 RST_OVERLAP = SEQ_RST_OVERLAP
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic                           x,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           z,
  output logic [CNT_W-1:0]               match_count,
  output logic                           cfg_err
);

  localparam int                 LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   RST_LEN_L = LEN_W'(RST_LEN);
  localparam logic               RST_ERR   = (RST_LEN == 0) || (RST_LEN > MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  if (MAX_LEN == SEQ_MAX_LEN) begin : g_pkg_mask
    assign mask = len_mask(len_t'(len_q));
  end else begin : g_loop_mask
    // Generic mask for non-default widths.
    always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < int'(len_q)) mask[i] = 1'b1;
      end
    end
  end

  assign hist_n = {hist_q[MAX_LEN-2:0], x};
  assign fill_n = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);

  // A load cycle drops the incoming bit, so it can never produce a hit.
  assign hit = en && !cfg_load && !err_q && (fill_n >= len_q)
               && (((hist_n ^ pat_q) & mask) == '0);

  // Next-state: configuration load has priority over an enabled bit.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    err_d  = err_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      err_d  = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_n;
      // Non-overlap hit restarts filling so the completing bit is not reused.
      fill_d = (hit && !ovl_q) ? '0 : fill_n;
      z_d    = hit;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_q  <= RST_PATTERN;
      len_q  <= RST_LEN_L;
      ovl_q  <= RST_OVERLAP;
      err_q  <= RST_ERR;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hit),
    .clr     (cnt_clr),
    .count   (match_count)
  );

  assign z       = z_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Randomised and directed bench for seq_det_prog with a queue-based reference
// model and a scoreboard monitor sampling one time unit after each rising edge.
module tb_seq_det_prog;

  localparam int MAXL = 8;
  localparam int LW   = 4;
  localparam int CW   = 2;

  typedef struct packed {
    logic          z;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            x = 1'b0;
  logic            cfg_load = 1'b0;
  logic [MAXL-1:0] cfg_pattern = '0;
  logic [LW-1:0]   cfg_len = '0;
  logic            cfg_overlap = 1'b0;
  logic            cnt_clr = 1'b0;
  logic            z;
  logic [CW-1:0]   match_count;
  logic            cfg_err;

  seq_det_prog #(
    .MAX_LEN (MAXL),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .x           (x),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .z           (z),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model state: bits received since the last restart point.
  bit              m_bits[$];
  logic [MAXL-1:0] m_pat = 8'b0000_0110;
  int              m_len = 4;
  bit              m_ovl = 1'b1;
  bit              m_err = 1'b0;
  int              m_cnt = 0;
  int              m_hits = 0;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic bit model_match();
    if (m_err || m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply one cycle of stimulus, advance the model and queue the expectation.
  task automatic drive(input logic rst, input logic e, input logic xb,
                       input logic ld, input logic clr,
                       input logic [MAXL-1:0] p, input logic [LW-1:0] l,
                       input logic o);
    exp_t ex;
    bit   hit;
    @(negedge clk);
    reset_n = ~rst; en = e; x = xb; cfg_load = ld; cnt_clr = clr;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    hit = 1'b0;
    if (rst) begin
      m_pat = 8'b0000_0110; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
      m_cnt = 0;
      m_bits.delete();
    end else begin
      if (ld) begin
        m_pat = p; m_len = int'(l); m_ovl = o;
        m_err = (l == 0) || (int'(l) > MAXL);
        m_bits.delete();
      end else if (e) begin
        m_bits.push_back(xb);
        if (m_bits.size() > MAXL) void'(m_bits.pop_front());
        hit = model_match();
        if (hit && !m_ovl) m_bits.delete();
      end
      if (clr) m_cnt = 0;
      else if (hit) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
    end
    if (hit) m_hits++;
    ex.z   = hit;
    ex.cnt = CW'(m_cnt);
    ex.err = m_err;
    sb_q.push_back(ex);
  endtask

  task automatic bit_in(input logic b);
    drive(1'b0, 1'b1, b, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(input logic [MAXL-1:0] p, input logic [LW-1:0] l, input logic o);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, p, l, o);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Scoreboard monitor: one expectation per clock, compared after the edge.
  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      check("z", int'(z), int'(ex.z));
      check("match_count", int'(match_count), int'(ex.cnt));
      check("cfg_err", int'(cfg_err), int'(ex.err));
    end
  end

  initial begin
    int budget;
    // Reset defaults: pattern 0110, overlap on.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    stream(32'b0110110, 7);
    idle();
    // 101 overlap, then non-overlap.
    load(8'b101, 4'd3, 1'b1);
    stream(32'b10101, 5);
    idle();
    load(8'b101, 4'd3, 1'b0);
    stream(32'b10101, 5);
    idle();
    // Enable gaps.
    load(8'b0110, 4'd4, 1'b1);
    bit_in(1'b0); idle(); bit_in(1'b1); idle(); idle(); idle();
    bit_in(1'b1); bit_in(1'b0); idle();
    // Full-length pattern.
    load(8'hA5, 4'd8, 1'b1);
    stream(32'hA5, 8);
    stream(32'h5A5, 12);
    // Illegal lengths.
    load(8'h00, 4'd0, 1'b1);
    stream(32'h0000, 10);
    load(8'hFF, 4'd9, 1'b1);
    stream(32'hFFF, 12);
    // Saturation and clear-vs-hit.
    load(8'b11, 4'd2, 1'b1);
    stream(32'h7F, 7);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    bit_in(1'b1);
    idle();
    // Mid-stream reset discards partial match.
    load(8'b0110, 4'd4, 1'b1);
    stream(32'b011, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    bit_in(1'b0);
    // Load coincident with completing bit.
    stream(32'b011, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0110, 4'd4, 1'b1);
    bit_in(1'b0);
    idle();
    // Randomised traffic with short patterns to get frequent hits.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        drive(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0, '0, 1'b0);
      end else if (r < 5) begin
        logic [LW-1:0] l;
        l = (r == 4) ? LW'($urandom_range(0, 9)) : LW'($urandom_range(1, 4));
        drive(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0),
              MAXL'($urandom), l, 1'($urandom));
      end else begin
        drive(1'b0, 1'($urandom_range(0, 9) != 0), 1'($urandom), 1'b0,
              1'($urandom_range(0, 29) == 0), '0, '0, 1'b0);
      end
    end
    idle();
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    check("model_hits_seen", int'(m_hits > 20), 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
